fetch_align_buffer: RTL and testbench



---
 rtl/fetch_align_pkg.sv | 23 ++
 rtl/align_slot_select.sv | 37 +++
 rtl/fetch_align_buffer.sv | 78 +++++++
 tb/tb_fetch_align_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared state type, width helpers and branch search for the fetch aligner
package fetch_align_pkg;
  typedef enum logic {NORMAL, WAIT_DS} state_t;
  localparam int MAX_FW = 64;
  typedef struct packed {
    logic found;
    logic [5:0] idx;
  } branch_t;
  function automatic int offs_w(input int fw);
    return $clog2(fw);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic branch_t first_branch(input logic [MAX_FW-1:0] group, input int offset);
    first_branch = '0;
    for (int k = MAX_FW - 1; k >= 0; k--)
      if (group[k] && k >= offset) begin
        first_branch.found = 1'b1;
        first_branch.idx = 6'(k);
      end
  endfunction
endpackage

// File: rtl/align_slot_select.sv
// align_slot_select: picks surviving slots of a fetch group and left-justifies them
module align_slot_select
  import fetch_align_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int INSN_WIDTH = 99,
  parameter int BRANCH_BIT = 9,
  localparam int OFFS_W = offs_w(FETCH_WIDTH)
) (
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] group,
  input  logic [OFFS_W-1:0]                 offset,
  input  state_t                            state,
  output logic [OFFS_W:0]                   kept,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] slots,
  output state_t                            next_state
);
  logic [MAX_FW-1:0] flags;
  branch_t fb;
  int last;
  logic [OFFS_W-1:0] src;
  always_comb begin
    flags = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) flags[k] = group[k*INSN_WIDTH+BRANCH_BIT];
    fb = first_branch(flags, int'(offset));
    // a branch in the last slot leaves its delay slot for the next group
    last = state == WAIT_DS ? int'(offset) :
           fb.found && int'(fb.idx) < FETCH_WIDTH - 1 ? int'(fb.idx) + 1 : FETCH_WIDTH - 1;
    kept = (OFFS_W+1)'(last - int'(offset) + 1);
    next_state = state == NORMAL && fb.found && int'(fb.idx) == FETCH_WIDTH - 1 ? WAIT_DS : NORMAL;
    slots = '0;
    src = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      src = offset + OFFS_W'(j);
      if (j <= last - int'(offset)) slots[j*INSN_WIDTH +: INSN_WIDTH] = group[int'(src)*INSN_WIDTH +: INSN_WIDTH];
    end
  end
endmodule

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: aligns fetch groups at the PC offset and queues them in a circular buffer
module fetch_align_buffer
  import fetch_align_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSN_WIDTH = 99,
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int BRANCH_BIT = 9
) (
  input  logic                              i_Clk,
  input  logic                              i_Reset,
  input  logic                              i_Flush,
  input  logic                              i_fetch_valid,
  output logic                              o_fetch_ready,
  input  logic [ADDRESS_WIDTH-1:0]          i_pc,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] i_isn,
  input  logic                              i_Stall,
  output logic [FETCH_WIDTH-1:0]            o_valid,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] o_isn,
  output logic [$clog2(DEPTH):0]            o_count
);
  localparam int OW = offs_w(FETCH_WIDTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, n, deq;
  state_t state, next_state;
  logic [OW:0] kept;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0] slots;
  logic accept;
  logic unused_pc;
  assign unused_pc = ^{i_pc[ADDRESS_WIDTH-1:OW+2], i_pc[1:0]};
  assign o_count = count;
  align_slot_select #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .INSN_WIDTH(INSN_WIDTH),
    .BRANCH_BIT(BRANCH_BIT)
  ) u_sel (
    .group(i_isn),
    .offset(i_pc[OW+1:2]),
    .state(state),
    .kept(kept),
    .slots(slots),
    .next_state(next_state)
  );
  always_comb begin
    o_fetch_ready = count <= CW'(DEPTH - FETCH_WIDTH);
    accept = i_fetch_valid && o_fetch_ready && !i_Flush;
    n = count < CW'(FETCH_WIDTH) ? count : CW'(FETCH_WIDTH);
    deq = i_Stall ? '0 : n;
    o_valid = '0;
    o_isn = '0;
    for (int j = 0; j < FETCH_WIDTH; j++)
      if (CW'(j) < n) begin
        o_valid[j] = 1'b1;
        o_isn[j*INSN_WIDTH +: INSN_WIDTH] = mem[head + PW'(j)];
      end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= NORMAL;
    end else begin
      head <= head + PW'(deq);
      tail <= accept ? tail + PW'(kept) : tail;
      count <= count + (accept ? CW'(kept) : '0) - deq;
      if (accept) state <= next_state;
    end
  end
  always_ff @(posedge i_Clk)
    if (accept)
      for (int j = 0; j < FETCH_WIDTH; j++)
        if ((OW+1)'(j) < kept) mem[tail + PW'(j)] <= slots[j*INSN_WIDTH +: INSN_WIDTH];
endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: randomized and directed checks against an instruction-queue model
module tb_fetch_align_buffer;
  localparam int AW = 32, IW = 99, FW = 4, DEPTH = 8, BB = 9, OW = $clog2(FW);
  logic clk = 0, rst = 0, flush = 0, fvalid = 0, stall = 0, ready;
  logic [AW-1:0] pc = '0;
  logic [FW*IW-1:0] isn = '0, oisn;
  logic [FW-1:0] valid;
  logic [$clog2(DEPTH):0] count;
  int compared = 0, mismatched = 0;
  logic [IW-1:0] q[$];
  bit m_wait = 0;

  always #5 clk = ~clk;

  fetch_align_buffer #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .FETCH_WIDTH(FW), .DEPTH(DEPTH), .BRANCH_BIT(BB)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Flush(flush), .i_fetch_valid(fvalid), .o_fetch_ready(ready),
    .i_pc(pc), .i_isn(isn), .i_Stall(stall), .o_valid(valid), .o_isn(oisn), .o_count(count)
  );

  function automatic logic [IW-1:0] rand_insn();
    logic [IW-1:0] v = IW'({$urandom, $urandom, $urandom, $urandom});
    v[BB] = 1'b0;
    return v;
  endfunction

  function automatic logic [FW-1:0] exp_valid();
    logic [FW-1:0] v = '0;
    for (int k = 0; k < FW && k < q.size(); k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [FW*IW-1:0] exp_isn();
    logic [FW*IW-1:0] r = '0;
    for (int k = 0; k < FW && k < q.size(); k++) r[k*IW +: IW] = q[k];
    return r;
  endfunction

  task automatic offer(input int off, input logic [FW-1:0] br);
    pc = ($urandom << (OW + 2)) | (AW'(off) << 2) | AW'($urandom_range(0, 3));
    for (int k = 0; k < FW; k++) begin
      isn[k*IW +: IW] = rand_insn();
      isn[k*IW+BB] = br[k];
    end
    fvalid = 1;
  endtask

  // model: a group contributes the slots from the offset up to the first branch's delay slot
  task automatic tick();
    logic [IW-1:0] kept[$];
    int off = int'(pc[OW+1:2]);
    int n = q.size() < FW ? q.size() : FW;
    bit acc = fvalid && (q.size() <= DEPTH - FW) && !flush;
    if (acc) begin
      if (m_wait) begin
        kept.push_back(isn[off*IW +: IW]);
        m_wait = 0;
      end else
        for (int k = off; k < FW; k++) begin
          kept.push_back(isn[k*IW +: IW]);
          if (isn[k*IW+BB]) begin
            if (k == FW - 1) m_wait = 1;
            else kept.push_back(isn[(k+1)*IW +: IW]);
            break;
          end
        end
    end
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      m_wait = 0;
    end else begin
      if (!stall) repeat (n) void'(q.pop_front());
      foreach (kept[i]) q.push_back(kept[i]);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    compared += 4;
    if (valid !== '0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (oisn !== '0) begin mismatched++; $display("FAIL reset_isn: got %h expected 0", oisn); end
    if (count !== '0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", ready); end
  endtask

  task automatic test_no_branch();
    offer(0, '0);
    tick();
    fvalid = 0;
    compared += 3;
    if (valid !== 4'b1111) begin mismatched++; $display("FAIL nobr_valid: got %b expected 1111", valid); end
    if (oisn !== exp_isn()) begin mismatched++; $display("FAIL nobr_isn: got %h expected %h", oisn, exp_isn()); end
    tick();
    if (count !== '0) begin mismatched++; $display("FAIL nobr_drain: got %0d expected 0", count); end
  endtask

  task automatic test_branch();
    int offs[2] = '{2, 0};
    logic [FW-1:0] brs[2] = '{4'b0100, 4'b0010};
    logic [FW-1:0] masks[2] = '{4'b0011, 4'b0111};
    for (int i = 0; i < 2; i++) begin
      offer(offs[i], brs[i]);
      tick();
      fvalid = 0;
      compared += 2;
      if (valid !== masks[i]) begin mismatched++; $display("FAIL branch%0d_valid: got %b expected %b", i, valid, masks[i]); end
      if (oisn !== exp_isn()) begin mismatched++; $display("FAIL branch%0d_isn: got %h expected %h", i, oisn, exp_isn()); end
      tick();
    end
  endtask

  task automatic test_delay_slot();
    offer(1, 4'b1000);
    tick();
    compared += 4;
    if (valid !== 4'b0111) begin mismatched++; $display("FAIL ds_first_valid: got %b expected 0111", valid); end
    if (oisn !== exp_isn()) begin mismatched++; $display("FAIL ds_first_isn: got %h expected %h", oisn, exp_isn()); end
    offer(0, 4'b1111);
    tick();
    fvalid = 0;
    if (valid !== 4'b0001) begin mismatched++; $display("FAIL ds_slot_valid: got %b expected 0001", valid); end
    if (oisn !== exp_isn()) begin mismatched++; $display("FAIL ds_slot_isn: got %h expected %h", oisn, exp_isn()); end
    tick();
  endtask

  task automatic test_full_stall();
    stall = 1;
    repeat (4) begin
      offer(0, '0);
      tick();
    end
    fvalid = 0;
    compared += 8;
    if (count !== 8) begin mismatched++; $display("FAIL full_count: got %0d expected 8", count); end
    if (ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %b expected 0", ready); end
    if (valid !== 4'b1111) begin mismatched++; $display("FAIL full_valid: got %b expected 1111", valid); end
    stall = 0;
    tick();
    if (count !== 4) begin mismatched++; $display("FAIL release_count: got %0d expected 4", count); end
    if (ready !== 1'b1) begin mismatched++; $display("FAIL release_ready: got %b expected 1", ready); end
    if (valid !== 4'b1111) begin mismatched++; $display("FAIL release_valid: got %b expected 1111", valid); end
    if (oisn !== exp_isn()) begin mismatched++; $display("FAIL release_isn: got %h expected %h", oisn, exp_isn()); end
    tick();
    if (count !== 0) begin mismatched++; $display("FAIL release_drain: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    stall = 1;
    offer(0, '0);
    tick();
    offer(3, 4'b1000);
    tick();
    compared += 4;
    if (count !== 5) begin mismatched++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    offer(0, '0);
    flush = 1;
    tick();
    flush = 0;
    fvalid = 0;
    stall = 0;
    if (count !== 0) begin mismatched++; $display("FAIL flush_count: got %0d expected 0", count); end
    if (valid !== '0) begin mismatched++; $display("FAIL flush_valid: got %b expected 0", valid); end
    offer(0, 4'b0010);
    tick();
    fvalid = 0;
    if (valid !== 4'b0111) begin mismatched++; $display("FAIL flush_state: got %b expected 0111", valid); end
    tick();
  endtask

  task automatic test_reset_midstream();
    offer(0, 4'b1000);
    tick();
    offer(1, '0);
    rst = 1;
    tick();
    rst = 0;
    fvalid = 0;
    compared += 5;
    if (valid !== '0) begin mismatched++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    if (oisn !== '0) begin mismatched++; $display("FAIL midrst_isn: got %h expected 0", oisn); end
    if (count !== '0) begin mismatched++; $display("FAIL midrst_count: got %0d expected 0", count); end
    if (ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    offer(2, '0);
    tick();
    fvalid = 0;
    if (valid !== 4'b0011) begin mismatched++; $display("FAIL midrst_state: got %b expected 0011", valid); end
    tick();
  endtask

  task automatic test_random();
    repeat (400) begin
      logic [FW-1:0] br;
      for (int k = 0; k < FW; k++) br[k] = $urandom_range(0, 3) == 0;
      offer($urandom_range(0, FW - 1), br);
      fvalid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 2) == 0;
      flush = $urandom_range(0, 24) == 0;
      tick();
      compared += 4;
      if (valid !== exp_valid()) begin mismatched++; $display("FAIL rand_valid: got %b expected %b", valid, exp_valid()); end
      if (oisn !== exp_isn()) begin mismatched++; $display("FAIL rand_isn: got %h expected %h", oisn, exp_isn()); end
      if (count !== 4'(q.size())) begin mismatched++; $display("FAIL rand_count: got %0d expected %0d", count, q.size()); end
      if (ready !== (q.size() <= DEPTH - FW)) begin mismatched++; $display("FAIL rand_ready: got %b expected %b", ready, q.size() <= DEPTH - FW); end
    end
    fvalid = 0;
    stall = 0;
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_no_branch();
    test_branch();
    test_delay_slot();
    test_full_stall();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
